// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit owning HI/LO. Sequences MULT/MULTU/DIV/DIVU
// one bit per cycle (IDLE -> RUN -> FIX -> IDLE) and stalls the front end
// while a result is pending.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             hilo_read,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state, next_state;
  logic               is_div, neg_res, neg_rem, div_zero;
  logic [WIDTH-1:0]   opa;      // multiplicand / divisor magnitude
  logic [WIDTH-1:0]   quo;      // dividend shifting out, quotient shifting in
  logic [2*WIDTH-1:0] acc;      // product accumulator, multiplier in low half
  logic [WIDTH:0]     rem;      // partial remainder
  logic [CW-1:0]      cnt;

  // Two's-complement negation under a condition, word and double-word forms.
  function automatic logic [WIDTH-1:0] cond_neg(input logic neg, input logic [WIDTH-1:0] v);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg_wide(input logic neg, input logic [2*WIDTH-1:0] v);
    return neg ? (~v + 1'b1) : v;
  endfunction

  logic             signed_op, rs_neg, rt_neg;
  logic [WIDTH-1:0] rs_mag, rt_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH+1:0] div_diff;
  logic             div_ok;

  // Operand magnitudes and one iteration step of each algorithm.
  always_comb begin
    signed_op = ~op[0];
    rs_neg    = signed_op & rs_val[WIDTH-1];
    rt_neg    = signed_op & rt_val[WIDTH-1];
    rs_mag    = cond_neg(rs_neg, rs_val);
    rt_mag    = cond_neg(rt_neg, rt_val);
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opa} : {(WIDTH+1){1'b0}});
    // rem never exceeds the divisor, so its top bit stays clear and the
    // extra leading bit of the difference acts as the borrow.
    div_diff  = {rem, quo[WIDTH-1]} - {2'b00, opa};
    div_ok    = ~div_diff[WIDTH+1];
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic: RUN lasts exactly WIDTH cycles (counter WIDTH down to 1).
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (cnt == CW'(1)) next_state = FIX;
      FIX:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign busy  = (state != IDLE);
  assign stall = busy & (hilo_read | start);

  // Operand capture, iteration, and sign-corrected HI/LO write at the end of FIX.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      opa      <= '0;
      quo      <= '0;
      acc      <= '0;
      rem      <= '0;
      cnt      <= '0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= (state == FIX);
      unique case (state)
        IDLE: if (start) begin
          is_div   <= op[1];
          neg_res  <= rs_neg ^ rt_neg;
          neg_rem  <= rs_neg;
          div_zero <= op[1] & (rt_val == '0);
          cnt      <= CW'(WIDTH);
          rem      <= '0;
          if (op[1]) begin
            opa <= rt_mag;
            quo <= rs_mag;
            acc <= '0;
          end else begin
            opa <= rs_mag;
            quo <= '0;
            acc <= {{WIDTH{1'b0}}, rt_mag};
          end
        end
        RUN: begin
          cnt <= cnt - CW'(1);
          if (is_div) begin
            rem <= div_ok ? div_diff[WIDTH:0] : {rem[WIDTH-1:0], quo[WIDTH-1]};
            quo <= {quo[WIDTH-2:0], div_ok};
          end else begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end
        end
        FIX: begin
          if (is_div) begin
            // A zero divisor leaves the dividend in rem, so the remainder
            // rule alone restores the raw rs value; only LO is forced.
            hi <= cond_neg(neg_rem, rem[WIDTH-1:0]);
            lo <= div_zero ? {WIDTH{1'b1}} : cond_neg(neg_res, quo);
          end else begin
            {hi, lo} <= cond_neg_wide(neg_res, acc);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed corner cases plus
// randomized ops against an arithmetic reference model.
module tb_muldiv_sequencer;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] rs_val = '0;
  logic [W-1:0] rt_val = '0;
  logic         hilo_read = 1'b0;
  logic         busy, stall, done;
  logic [W-1:0] hi, lo;

  int n_tests = 0;
  int n_fail  = 0;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .hilo_read (hilo_read),
    .busy      (busy),
    .stall     (stall),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference result {hi, lo} from plain arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    longint   sa, sb, sq, sr;
    logic [63:0] ua, ub, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (o)
      2'b00: r = sa * sb;
      2'b01: r = ua * ub;
      2'b10: begin
        if (b == '0) r = {a, 32'hFFFF_FFFF};
        else begin
          sq = sa / sb;
          sr = sa % sb;
          r  = {sr[31:0], sq[31:0]};
        end
      end
      default: begin
        if (b == '0) r = {a, 32'hFFFF_FFFF};
        else begin
          sq = longint'(ua / ub);
          sr = longint'(ua % ub);
          r  = {sr[31:0], sq[31:0]};
        end
      end
    endcase
    return r;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h0000_0001;
      4: return 32'(($urandom_range(0, 15)));
      default: return $urandom;
    endcase
  endfunction

  // Issues one op at the current negedge (FSM idle) and returns at the
  // negedge of the done cycle, having checked every cycle in between.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit hold_read, input bit poke_start);
    logic [63:0]  exp;
    logic [W-1:0] hi0, lo0;
    exp = model(o, a, b);
    hi0 = hi;
    lo0 = lo;
    start = 1'b1; op = o; rs_val = a; rt_val = b; hilo_read = hold_read;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0; rs_val = $urandom; rt_val = $urandom;
    for (int k = 1; k <= W + 1; k++) begin
      if (poke_start && k == 5) begin
        start = 1'b1; op = ~o; rs_val = $urandom; rt_val = $urandom;
        #1;
        check("stall_on_busy_start", {63'b0, stall}, 64'd1);
      end else if (poke_start && k == 6) begin
        start = 1'b0;
      end
      check("busy_run", {63'b0, busy}, 64'd1);
      check("done_early", {63'b0, done}, 64'd0);
      check("hilo_held", {hi, lo}, {hi0, lo0});
      if (hold_read) check("stall_on_read", {63'b0, stall}, 64'd1);
      @(negedge clock);
    end
    check("done_pulse", {63'b0, done}, 64'd1);
    check("busy_done_cycle", {63'b0, busy}, 64'd0);
    check("stall_idle", {63'b0, stall}, 64'd0);
    check($sformatf("result_op%0d_%h_%h", o, a, b), {hi, lo}, exp);
    hilo_read = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clock);
    start = 1'b1; hilo_read = 1'b1;
    #1;
    check("reset_busy", {63'b0, busy}, 64'd0);
    check("reset_done", {63'b0, done}, 64'd0);
    check("reset_stall", {63'b0, stall}, 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    @(negedge clock);
    start = 1'b0; hilo_read = 1'b0;
    reset = 1'b1;
    @(negedge clock);

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    @(negedge clock);
    check("done_one_cycle", {63'b0, done}, 64'd0);
    run_op(2'b00, -32'sd3, 32'd7, 1'b1, 1'b0);
    @(negedge clock);
    run_op(2'b10, -32'sd7, 32'd2, 1'b0, 1'b0);
    @(negedge clock);
    run_op(2'b11, 32'd7, 32'd0, 1'b0, 1'b0);
    @(negedge clock);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(2'b01, 32'd6, 32'd7, 1'b0, 1'b0);   // issued in the done cycle
    @(negedge clock);
    run_op(2'b00, 32'd1234, -32'sd55, 1'b0, 1'b1);
    @(negedge clock);

    // Reset in the 10th RUN cycle.
    start = 1'b1; op = 2'b01; rs_val = 32'h1234; rt_val = 32'h5678;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    reset = 1'b0;
    #1;
    check("midrun_reset_busy", {63'b0, busy}, 64'd0);
    check("midrun_reset_done", {63'b0, done}, 64'd0);
    check("midrun_reset_hilo", {hi, lo}, 64'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    run_op(2'b01, 32'd6, 32'd7, 1'b0, 1'b0);
    @(negedge clock);

    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom_range(0, 3)), pick(), pick(), bit'($urandom_range(0, 1)), 1'b0);
      if ($urandom_range(0, 2) != 0) @(negedge clock);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
